// File: rtl/prg_cache_pkg.sv
// rtl/prg_cache_pkg.sv - shared types and geometry constants for the program cache
package prg_cache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        REFILL = 2'd2
    } prg_cache_state_t;

    localparam int DEF_LINE_BITS   = 6;
    localparam int DEF_OFFSET_BITS = 2;

    function automatic int tag_bits(input int line_bits, input int offset_bits);
        return 32 - line_bits - offset_bits;
    endfunction

    localparam int TAG_BITS = tag_bits(DEF_LINE_BITS, DEF_OFFSET_BITS);

endpackage

// File: rtl/prg_cache_ram.sv
// rtl/prg_cache_ram.sv - simple dual-port RAM, one write port, one registered read port
module prg_cache_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the output register is reset so the array itself can map onto block RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/prg_cache.sv
// rtl/prg_cache.sv - direct-mapped read-only program cache; PRG_CACHE_FLUSH_EN adds a flush input
module prg_cache
    import prg_cache_pkg::*;
#(
    parameter int LINE_BITS   = DEF_LINE_BITS,
    parameter int OFFSET_BITS = DEF_OFFSET_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] prg_address,
    output logic [15:0] prg_data,
    output logic        p_cache_miss,
    output logic [31:0] mem_address,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [15:0] mem_data
`ifdef PRG_CACHE_FLUSH_EN
    ,
    input  logic        flush
`endif
);

    localparam int IW     = LINE_BITS + OFFSET_BITS;
    localparam int TB     = tag_bits(LINE_BITS, OFFSET_BITS);
    localparam int NLINES = 2**LINE_BITS;

    prg_cache_state_t       state, state_nxt;
    logic [31:OFFSET_BITS]  a_q;
    logic                   lookup_valid;
    logic [OFFSET_BITS-1:0] cnt;
    logic [NLINES-1:0]      valid;
    logic [TB-1:0]          tag_q;
    logic [LINE_BITS-1:0]   idx_q;
    logic                   tag_miss;
    logic                   load;
    logic                   fill_ack;
    logic                   fill_last;
    logic                   flush_now;

    assign idx_q     = a_q[IW-1:OFFSET_BITS];
    assign tag_miss  = lookup_valid & (~valid[idx_q] | (tag_q != a_q[31:IW]));
    // The PC must stall through the whole fill, including the REFILL re-read cycle.
    assign p_cache_miss = (state != IDLE) | tag_miss;
    assign load      = ((state == IDLE) & ~tag_miss) | (state == REFILL);
    assign fill_ack  = (state == FILL) & mem_ack;
    assign fill_last = fill_ack & (cnt == '1);

    always_comb begin
        state_nxt   = state;
        mem_req     = 1'b0;
        mem_address = '0;
        case (state)
            IDLE: begin
                if (tag_miss) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                mem_req     = 1'b1;
                mem_address = {a_q, cnt};
                if (fill_last) begin
                    state_nxt = REFILL;
                end
            end
            REFILL: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q          <= '0;
            lookup_valid <= 1'b0;
        end else if (load) begin
            a_q          <= prg_address[31:OFFSET_BITS];
            lookup_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if ((state == IDLE) & tag_miss) begin
            cnt <= '0;
        end else if (fill_ack) begin
            cnt <= cnt + 1'b1;
        end
    end

`ifdef PRG_CACHE_FLUSH_EN
    logic flush_pend;

    // A flush seen mid-fill is deferred to the REFILL exit so it also drops the new line.
    assign flush_now = ((state == IDLE) & flush) | ((state == REFILL) & (flush | flush_pend));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_pend <= 1'b0;
        end else if (state == REFILL) begin
            flush_pend <= 1'b0;
        end else if ((state == FILL) & flush) begin
            flush_pend <= 1'b1;
        end
    end
`else
    assign flush_now = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (flush_now) begin
            valid <= '0;
        end else if (fill_last) begin
            valid[idx_q] <= 1'b1;
        end
    end

    prg_cache_ram #(.ADDR_W(IW), .DATA_W(16)) u_data_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (fill_ack),
        .waddr ({idx_q, cnt}),
        .wdata (mem_data),
        .re    (load),
        .raddr (prg_address[IW-1:0]),
        .rdata (prg_data)
    );

    prg_cache_ram #(.ADDR_W(LINE_BITS), .DATA_W(TB)) u_tag_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (fill_last),
        .waddr (idx_q),
        .wdata (a_q[31:IW]),
        .re    (load),
        .raddr (prg_address[IW-1:OFFSET_BITS]),
        .rdata (tag_q)
    );

endmodule

// File: tb/tb_prg_cache.sv
// tb/tb_prg_cache.sv - directed self-checking bench for prg_cache
module tb_prg_cache;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] prg_address = '0;
    logic [15:0] prg_data;
    logic        p_cache_miss;
    logic [31:0] mem_address;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_data;
`ifdef PRG_CACHE_FLUSH_EN
    logic        flush = 1'b0;
    logic        flush_in_fill = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] addr_log [16];
    int words, miss_cycles, req_cycles;

    always #5 clk = ~clk;

    function automatic logic [15:0] word_of(input logic [31:0] a);
        return a[15:0] ^ 16'h5A3C;
    endfunction

    assign mem_data = mem_ack ? word_of(mem_address) : 16'hDEAD;

    prg_cache dut (
        .clk          (clk),
        .rst          (rst),
        .prg_address  (prg_address),
        .prg_data     (prg_data),
        .p_cache_miss (p_cache_miss),
        .mem_address  (mem_address),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .mem_data     (mem_data)
`ifdef PRG_CACHE_FLUSH_EN
        ,
        .flush        (flush)
`endif
    );

    task automatic run_fetch(input logic [31:0] addr, input logic [7:0] pat, input int pat_len);
        int  k;
        bit  done;
        k = 0; done = 0; words = 0; miss_cycles = 0; req_cycles = 0;
        prg_address = addr;
        @(posedge clk); #1;
        for (int i = 0; i < 60 && !done; i++) begin
            if (p_cache_miss) begin
                miss_cycles++;
                if (mem_req) begin
                    req_cycles++;
                    mem_ack = (k < pat_len) ? pat[k[2:0]] : 1'b1;
                    k++;
                    if (mem_ack) begin
                        if (words < 16) addr_log[words] = mem_address;
                        words++;
                    end
`ifdef PRG_CACHE_FLUSH_EN
                    flush = flush_in_fill && (req_cycles == 1);
`endif
                end else begin
                    mem_ack = 1'b0;
`ifdef PRG_CACHE_FLUSH_EN
                    flush = 1'b0;
`endif
                end
                @(posedge clk); #1;
            end else begin
                done = 1;
            end
        end
        mem_ack = 1'b0;
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL fetch_timeout addr=%h: miss still high after %0d cycles, required low", addr, miss_cycles);
        end
    endtask

    task automatic hit_line(input logic [31:0] base, input string name);
        for (int i = 0; i < 4; i++) begin
            prg_address = base + i;
            @(posedge clk); #1;
            n_cmp++;
            if (p_cache_miss !== 1'b0 || prg_data !== word_of(base + i)) begin
                n_bad++;
                $display("FAIL %s[%0d]: miss=%b data=%h, required miss=0 data=%h",
                         name, i, p_cache_miss, prg_data, word_of(base + i));
            end
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        n_cmp++;
        if (p_cache_miss !== 1'b0 || mem_req !== 1'b0 || mem_address !== 32'h0 || prg_data !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_values: miss=%b req=%b maddr=%h data=%h, required all 0",
                     p_cache_miss, mem_req, mem_address, prg_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_cold_miss();
        run_fetch(32'h10, 8'h00, 0);
        n_cmp++;
        if (miss_cycles !== 6) begin
            n_bad++; $display("FAIL cold_miss_cycles: got %0d required 6", miss_cycles);
        end
        n_cmp++;
        if (words !== 4 || req_cycles !== 4) begin
            n_bad++; $display("FAIL cold_acks: words=%0d req=%0d required 4/4", words, req_cycles);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (addr_log[i] !== 32'h10 + i) begin
                n_bad++; $display("FAIL cold_mem_address[%0d]: got %h required %h", i, addr_log[i], 32'h10 + i);
            end
        end
        n_cmp++;
        if (prg_data !== 16'h5A2C) begin
            n_bad++; $display("FAIL cold_data: got %h required 5a2c", prg_data);
        end
    endtask

    task automatic test_seq_hits();
        hit_line(32'h10, "seq_hit");
    endtask

    task automatic test_conflict();
        run_fetch(32'h110, 8'h00, 0);
        n_cmp++;
        if (miss_cycles !== 6 || prg_data !== 16'h5B2C) begin
            n_bad++; $display("FAIL conflict_fill: cycles=%0d data=%h required 6/5b2c", miss_cycles, prg_data);
        end
        run_fetch(32'h10, 8'h00, 0);
        n_cmp++;
        if (miss_cycles !== 6 || prg_data !== 16'h5A2C) begin
            n_bad++; $display("FAIL conflict_refetch: cycles=%0d data=%h required 6/5a2c", miss_cycles, prg_data);
        end
    endtask

    task automatic test_stall();
        run_fetch(32'h48, 8'h59, 7);
        n_cmp++;
        if (words !== 4 || req_cycles !== 7 || miss_cycles !== 9) begin
            n_bad++;
            $display("FAIL stall_counts: words=%0d req=%0d miss=%0d required 4/7/9", words, req_cycles, miss_cycles);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (addr_log[i] !== 32'h48 + i) begin
                n_bad++; $display("FAIL stall_mem_address[%0d]: got %h required %h", i, addr_log[i], 32'h48 + i);
            end
        end
        n_cmp++;
        if (mem_req !== 1'b0) begin
            n_bad++; $display("FAIL stall_req_drop: got %b required 0", mem_req);
        end
        hit_line(32'h48, "stall_hit");
    endtask

    task automatic test_reset_mid_fill();
        prg_address = 32'h20;
        mem_ack = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++;
        if (mem_req !== 1'b1 || mem_address !== 32'h21) begin
            n_bad++; $display("FAIL midfill_setup: req=%b maddr=%h required 1/00000021", mem_req, mem_address);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (p_cache_miss !== 1'b0 || mem_req !== 1'b0 || mem_address !== 32'h0 || prg_data !== 16'h0) begin
            n_bad++;
            $display("FAIL midfill_reset: miss=%b req=%b maddr=%h data=%h, required all 0",
                     p_cache_miss, mem_req, mem_address, prg_data);
        end
        mem_ack = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        run_fetch(32'h20, 8'h00, 0);
        n_cmp++;
        if (miss_cycles !== 6 || prg_data !== 16'h5A1C) begin
            n_bad++; $display("FAIL midfill_refetch: cycles=%0d data=%h required 6/5a1c", miss_cycles, prg_data);
        end
        run_fetch(32'h10, 8'h00, 0);
        n_cmp++;
        if (miss_cycles !== 6) begin
            n_bad++; $display("FAIL midfill_other_line: cycles=%0d required 6", miss_cycles);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] seq [6];
        seq[0] = 32'h20; seq[1] = 32'h10; seq[2] = 32'h23;
        seq[3] = 32'h13; seq[4] = 32'h11; seq[5] = 32'h22;
        mem_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            prg_address = seq[i];
            @(posedge clk); #1;
            n_cmp++;
            if (p_cache_miss !== 1'b0 || mem_req !== 1'b0 || prg_data !== word_of(seq[i])) begin
                n_bad++;
                $display("FAIL b2b[%0d]: miss=%b req=%b data=%h required 0/0/%h",
                         i, p_cache_miss, mem_req, prg_data, word_of(seq[i]));
            end
        end
        mem_ack = 1'b0;
    endtask

`ifdef PRG_CACHE_FLUSH_EN
    task automatic test_flush();
        flush = 1'b1;
        run_fetch(32'h10, 8'h00, 0);
        flush = 1'b0;
        n_cmp++;
        if (miss_cycles !== 6 || prg_data !== 16'h5A2C) begin
            n_bad++; $display("FAIL flush_idle: cycles=%0d data=%h required 6/5a2c", miss_cycles, prg_data);
        end
        flush_in_fill = 1'b1;
        run_fetch(32'h48, 8'h00, 0);
        flush_in_fill = 1'b0;
        flush = 1'b0;
        n_cmp++;
        if (miss_cycles !== 12 || prg_data !== 16'h5A74) begin
            n_bad++; $display("FAIL flush_fill: cycles=%0d data=%h required 12/5a74", miss_cycles, prg_data);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_cold_miss();
        test_seq_hits();
        test_conflict();
        test_stall();
        test_reset_mid_fill();
        test_back_to_back();
`ifdef PRG_CACHE_FLUSH_EN
        test_flush();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
